// File: rtl/pcie_sym_pkg.sv
// Symbol constants, decoded-symbol codes and framing state encoding shared by
// the PCIe symbol transmit mux and receiver.
package pcie_sym_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned LEN_W  = 8;

  localparam logic [BYTE_W-1:0] SYM_COM = 8'hF2;
  localparam logic [BYTE_W-1:0] SYM_PAD = 8'hC7;
  localparam logic [BYTE_W-1:0] SYM_SKP = 8'hAC;
  localparam logic [BYTE_W-1:0] SYM_STP = 8'hAA;
  localparam logic [BYTE_W-1:0] SYM_SDP = 8'hE5;
  localparam logic [BYTE_W-1:0] SYM_END = 8'hF6;
  localparam logic [BYTE_W-1:0] SYM_EDB = 8'hDF;
  localparam logic [BYTE_W-1:0] SYM_FTS = 8'hA8;
  localparam logic [BYTE_W-1:0] SYM_IDL = 8'hAE;

  localparam logic [CODE_W-1:0] CODE_TLP = 4'd0;
  localparam logic [CODE_W-1:0] CODE_COM = 4'd1;
  localparam logic [CODE_W-1:0] CODE_PAD = 4'd2;
  localparam logic [CODE_W-1:0] CODE_SKP = 4'd3;
  localparam logic [CODE_W-1:0] CODE_STP = 4'd4;
  localparam logic [CODE_W-1:0] CODE_SDP = 4'd5;
  localparam logic [CODE_W-1:0] CODE_END = 4'd6;
  localparam logic [CODE_W-1:0] CODE_EDB = 4'd7;
  localparam logic [CODE_W-1:0] CODE_FTS = 4'd8;
  localparam logic [CODE_W-1:0] CODE_IDL = 4'd9;
  localparam logic [CODE_W-1:0] CODE_UNK = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

endpackage

// File: rtl/pcie_symbol_receiver_if.sv
// Byte/K input stream and decoded-symbol output bundle of the symbol receiver.
interface pcie_symbol_receiver_if;
  import pcie_sym_pkg::*;

  logic                ENB;
  logic [BYTE_W-1:0]   IN_BYTE;
  logic                IN_K;
  logic [CODE_W-1:0]   OUT_CTRL;
  logic [BYTE_W-1:0]   OUT_BYTE;
  logic                OUT_VALID;
  logic                OUT_DATA_VALID;
  logic                OUT_PKT_DONE;
  logic                OUT_PKT_ABORT;
  logic [LEN_W-1:0]    OUT_LEN;
  logic                OUT_ERR;

  modport master (
    output ENB, IN_BYTE, IN_K,
    input  OUT_CTRL, OUT_BYTE, OUT_VALID, OUT_DATA_VALID,
           OUT_PKT_DONE, OUT_PKT_ABORT, OUT_LEN, OUT_ERR
  );

  modport slave (
    input  ENB, IN_BYTE, IN_K,
    output OUT_CTRL, OUT_BYTE, OUT_VALID, OUT_DATA_VALID,
           OUT_PKT_DONE, OUT_PKT_ABORT, OUT_LEN, OUT_ERR
  );
endinterface

// File: rtl/pcie_sym_decode.sv
// Combinational classification of a received byte plus K flag into a symbol code.
module pcie_sym_decode
  import pcie_sym_pkg::*;
(
  input  logic [BYTE_W-1:0] sym_byte,
  input  logic              sym_k,
  output logic [CODE_W-1:0] code_c
);

  always_comb begin
    code_c = CODE_TLP;
    if (sym_k) begin
      unique case (sym_byte)
        SYM_COM: code_c = CODE_COM;
        SYM_PAD: code_c = CODE_PAD;
        SYM_SKP: code_c = CODE_SKP;
        SYM_STP: code_c = CODE_STP;
        SYM_SDP: code_c = CODE_SDP;
        SYM_END: code_c = CODE_END;
        SYM_EDB: code_c = CODE_EDB;
        SYM_FTS: code_c = CODE_FTS;
        SYM_IDL: code_c = CODE_IDL;
        default: code_c = CODE_UNK;
      endcase
    end
  end

endmodule

// File: rtl/pcie_symbol_receiver.sv
// Receive-side symbol classifier with STP/SDP..END/EDB framing, payload length
// tracking and protocol-violation flagging.
module pcie_symbol_receiver
  import pcie_sym_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64
) (
  input  logic                  CLK_2MHz,
  input  logic                  reset,
  pcie_symbol_receiver_if.slave bus
);

  logic [CODE_W-1:0] code_c;
  state_e            state, state_nxt;
  logic [LEN_W-1:0]  len, len_nxt;

  logic [CODE_W-1:0] ctrl_q, ctrl_nxt;
  logic [BYTE_W-1:0] byte_q, byte_nxt;
  logic [LEN_W-1:0]  olen_q, olen_nxt;
  logic              valid_q, valid_nxt;
  logic              dv_q, dv_nxt;
  logic              done_q, done_nxt;
  logic              abort_q, abort_nxt;
  logic              err_q, err_nxt;

  pcie_sym_decode u_decode (
    .sym_byte (bus.IN_BYTE),
    .sym_k    (bus.IN_K),
    .code_c   (code_c)
  );

  always_ff @(posedge CLK_2MHz) begin
    if (reset) begin
      state <= ST_IDLE;
      len   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
    end
  end

  // Framing decisions; when disabled everything but the held fields idles.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    ctrl_nxt  = ctrl_q;
    byte_nxt  = byte_q;
    olen_nxt  = olen_q;
    valid_nxt = 1'b0;
    dv_nxt    = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (bus.ENB) begin
      valid_nxt = 1'b1;
      ctrl_nxt  = code_c;
      byte_nxt  = bus.IN_BYTE;
      unique case (state)
        ST_IDLE: begin
          unique case (code_c)
            CODE_STP, CODE_SDP: begin
              state_nxt = ST_PKT;
              len_nxt   = '0;
            end
            CODE_COM, CODE_PAD, CODE_SKP, CODE_FTS, CODE_IDL: ;
            default: err_nxt = 1'b1;
          endcase
        end
        ST_PKT: begin
          unique case (code_c)
            CODE_TLP: begin
              if (len < LEN_W'(MAX_LEN)) begin
                dv_nxt  = 1'b1;
                len_nxt = len + LEN_W'(1);
              end else begin
                err_nxt   = 1'b1;
                abort_nxt = 1'b1;
                olen_nxt  = LEN_W'(MAX_LEN);
                state_nxt = ST_IDLE;
              end
            end
            CODE_END: begin
              done_nxt  = 1'b1;
              olen_nxt  = len;
              state_nxt = ST_IDLE;
            end
            CODE_EDB: begin
              abort_nxt = 1'b1;
              olen_nxt  = len;
              state_nxt = ST_IDLE;
            end
            // A new start inside a packet drops the old one and restarts framing.
            CODE_STP, CODE_SDP: begin
              err_nxt   = 1'b1;
              abort_nxt = 1'b1;
              olen_nxt  = len;
              len_nxt   = '0;
            end
            default: begin
              err_nxt   = 1'b1;
              abort_nxt = 1'b1;
              olen_nxt  = len;
              state_nxt = ST_IDLE;
            end
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_2MHz) begin
    if (reset) begin
      ctrl_q  <= '0;
      byte_q  <= '0;
      olen_q  <= '0;
      valid_q <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_nxt;
      byte_q  <= byte_nxt;
      olen_q  <= olen_nxt;
      valid_q <= valid_nxt;
      dv_q    <= dv_nxt;
      done_q  <= done_nxt;
      abort_q <= abort_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.OUT_CTRL       = ctrl_q;
  assign bus.OUT_BYTE       = byte_q;
  assign bus.OUT_LEN        = olen_q;
  assign bus.OUT_VALID      = valid_q;
  assign bus.OUT_DATA_VALID = dv_q;
  assign bus.OUT_PKT_DONE   = done_q;
  assign bus.OUT_PKT_ABORT  = abort_q;
  assign bus.OUT_ERR        = err_q;

endmodule

// File: tb/tb_pcie_symbol_receiver.sv
// Directed bench for pcie_symbol_receiver built with a 4-byte payload limit.
module tb_pcie_symbol_receiver;

  logic CLK_2MHz = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  pcie_symbol_receiver_if bus ();

  pcie_symbol_receiver #(.MAX_LEN(4)) dut (
    .CLK_2MHz (CLK_2MHz),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLK_2MHz = ~CLK_2MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input beat and sample its registered result just after the edge.
  task automatic step(input logic enb, input logic k, input logic [7:0] b);
    @(negedge CLK_2MHz);
    bus.ENB     = enb;
    bus.IN_K    = k;
    bus.IN_BYTE = b;
    @(posedge CLK_2MHz);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ctrl, input logic valid,
                         input logic dv, input logic done, input logic abort,
                         input logic err, input logic [7:0] len);
    chk({tag, ".ctrl"},  32'(bus.OUT_CTRL),       32'(ctrl));
    chk({tag, ".valid"}, 32'(bus.OUT_VALID),      32'(valid));
    chk({tag, ".dv"},    32'(bus.OUT_DATA_VALID), 32'(dv));
    chk({tag, ".done"},  32'(bus.OUT_PKT_DONE),   32'(done));
    chk({tag, ".abort"}, 32'(bus.OUT_PKT_ABORT),  32'(abort));
    chk({tag, ".err"},   32'(bus.OUT_ERR),        32'(err));
    chk({tag, ".len"},   32'(bus.OUT_LEN),        32'(len));
  endtask

  initial begin
    reset       = 1'b1;
    bus.ENB     = 1'b1;
    bus.IN_K    = 1'b0;
    bus.IN_BYTE = 8'h00;
    repeat (4) step(1'b1, 1'b0, 8'h00);
    chk_all("rst", 4'd0, 0, 0, 0, 0, 0, 8'd0);
    chk("rst.byte", 32'(bus.OUT_BYTE), 32'h0);
    reset = 1'b0;

    // Basic packet: STP, three data bytes, END
    step(1, 1, 8'hAA); chk_all("p1.stp", 4'd4, 1, 0, 0, 0, 0, 8'd0);
    step(1, 0, 8'h11); chk_all("p1.d0",  4'd0, 1, 1, 0, 0, 0, 8'd0);
    chk("p1.d0.byte", 32'(bus.OUT_BYTE), 32'h11);
    step(1, 0, 8'h22); chk_all("p1.d1",  4'd0, 1, 1, 0, 0, 0, 8'd0);
    step(1, 0, 8'h33); chk_all("p1.d2",  4'd0, 1, 1, 0, 0, 0, 8'd0);
    chk("p1.d2.byte", 32'(bus.OUT_BYTE), 32'h33);
    step(1, 1, 8'hF6); chk_all("p1.end", 4'd6, 1, 0, 1, 0, 0, 8'd3);

    // Every K symbol, closing packets where they open
    step(1, 1, 8'hF2); chk_all("k.com",  4'd1, 1, 0, 0, 0, 0, 8'd3);
    step(1, 1, 8'hC7); chk_all("k.pad",  4'd2, 1, 0, 0, 0, 0, 8'd3);
    step(1, 1, 8'hAC); chk_all("k.skp",  4'd3, 1, 0, 0, 0, 0, 8'd3);
    step(1, 1, 8'hAA); chk_all("k.stp",  4'd4, 1, 0, 0, 0, 0, 8'd3);
    step(1, 1, 8'hF6); chk_all("k.end0", 4'd6, 1, 0, 1, 0, 0, 8'd0);
    step(1, 1, 8'hE5); chk_all("k.sdp",  4'd5, 1, 0, 0, 0, 0, 8'd0);
    step(1, 1, 8'hF6); chk_all("k.end1", 4'd6, 1, 0, 1, 0, 0, 8'd0);
    step(1, 1, 8'hDF); chk_all("k.edb_idle", 4'd7, 1, 0, 0, 0, 1, 8'd0);
    step(1, 1, 8'hA8); chk_all("k.fts",  4'd8, 1, 0, 0, 0, 0, 8'd0);
    step(1, 1, 8'hAE); chk_all("k.idl",  4'd9, 1, 0, 0, 0, 0, 8'd0);
    step(1, 1, 8'hF6); chk_all("k.end_idle", 4'd6, 1, 0, 0, 0, 1, 8'd0);
    step(1, 1, 8'h0A); chk_all("k.unk_idle", 4'd15, 1, 0, 0, 0, 1, 8'd0);

    // SDP packet aborted by EDB, then stray data in IDLE
    step(1, 1, 8'hE5); chk_all("edb.sdp", 4'd5, 1, 0, 0, 0, 0, 8'd0);
    step(1, 0, 8'hFF); chk_all("edb.d0",  4'd0, 1, 1, 0, 0, 0, 8'd0);
    step(1, 1, 8'hDF); chk_all("edb.edb", 4'd7, 1, 0, 0, 1, 0, 8'd1);
    step(1, 0, 8'h0A); chk_all("edb.stray", 4'd0, 1, 0, 0, 0, 1, 8'd1);

    // Payload overflow at the 4-byte limit
    step(1, 1, 8'hAA); chk_all("ovf.stp", 4'd4, 1, 0, 0, 0, 0, 8'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'(8'h40 + i)); chk_all($sformatf("ovf.d%0d", i), 4'd0, 1, 1, 0, 0, 0, 8'd1);
    end
    step(1, 0, 8'h44); chk_all("ovf.d4",  4'd0, 1, 0, 0, 1, 1, 8'd4);
    step(1, 0, 8'h55); chk_all("ovf.idle", 4'd0, 1, 0, 0, 0, 1, 8'd4);

    // Restart inside a packet, then unknown K inside a packet
    step(1, 1, 8'hAA); chk_all("rs.stp0", 4'd4, 1, 0, 0, 0, 0, 8'd4);
    step(1, 0, 8'h01); chk_all("rs.d0",   4'd0, 1, 1, 0, 0, 0, 8'd4);
    step(1, 1, 8'hAA); chk_all("rs.stp1", 4'd4, 1, 0, 0, 1, 1, 8'd1);
    step(1, 0, 8'h02); chk_all("rs.d1",   4'd0, 1, 1, 0, 0, 0, 8'd1);
    step(1, 1, 8'hF6); chk_all("rs.end",  4'd6, 1, 0, 1, 0, 0, 8'd1);
    step(1, 1, 8'hAA); chk_all("uk.stp",  4'd4, 1, 0, 0, 0, 0, 8'd1);
    step(1, 1, 8'h0A); chk_all("uk.unk",  4'd15, 1, 0, 0, 1, 1, 8'd0);

    // Enable dropped mid-packet: state and length frozen, K:F6 ignored
    step(1, 1, 8'hAA); chk_all("en.stp", 4'd4, 1, 0, 0, 0, 0, 8'd0);
    step(1, 0, 8'h01); chk_all("en.d0",  4'd0, 1, 1, 0, 0, 0, 8'd0);
    step(1, 0, 8'h02); chk_all("en.d1",  4'd0, 1, 1, 0, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'hF6); chk_all($sformatf("en.off%0d", i), 4'd0, 0, 0, 0, 0, 0, 8'd0);
      chk($sformatf("en.off%0d.byte", i), 32'(bus.OUT_BYTE), 32'h02);
    end
    step(1, 0, 8'h03); chk_all("en.d2",  4'd0, 1, 1, 0, 0, 0, 8'd0);
    step(1, 1, 8'hF6); chk_all("en.end", 4'd6, 1, 0, 1, 0, 0, 8'd3);

    // Reset mid-packet drops it silently
    step(1, 1, 8'hAA); chk_all("mr.stp", 4'd4, 1, 0, 0, 0, 0, 8'd3);
    step(1, 0, 8'h01); chk_all("mr.d0",  4'd0, 1, 1, 0, 0, 0, 8'd3);
    reset = 1'b1;
    step(1, 0, 8'h02); chk_all("mr.rst", 4'd0, 0, 0, 0, 0, 0, 8'd0);
    chk("mr.rst.byte", 32'(bus.OUT_BYTE), 32'h0);
    reset = 1'b0;
    step(1, 1, 8'hF6); chk_all("mr.end_idle", 4'd6, 1, 0, 0, 0, 1, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
